video_syn_polarity_norm: RTL and testbench
==========================================

Name: video_syn_polarity_norm

Overview:
- Multi-channel successor to the single-vsync polarity detector.
- Per channel: measures high and low phase lengths of an incoming sync, votes polarity over VOTE_N consecutive periods, and optionally re-drives the sync as active-high.
- Also reports measured period, pulse width and lock/loss status for the timing-detect logic.
- Sits between the video input pins and the timing generator or frame-capture logic.

Parameters:
- NUM_CH, 2, number of independent sync channels (ch0 = vsync, ch1 = hsync by convention).
- CNT_W, 24, phase/period counter width; counters saturate at 2^CNT_W-1.
- VOTE_N, 3, consecutive agreeing periods required to commit a polarity (legal range 1..15).

Ports:
- i_clk, input, 1: system clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_syn, input, NUM_CH: raw sync inputs, asynchronous to i_clk.
- i_inv_en, input, NUM_CH: per-channel enable for polarity normalisation.
- o_syn, output, NUM_CH: normalised (active-high) or passed-through sync.
- o_pol, output, NUM_CH: committed polarity; 1 = high phase longer (active-low sync).
- o_locked, output, NUM_CH: polarity committed and sync still toggling.
- o_period, output, NUM_CH*CNT_W: last measured period in cycles; ch n occupies bits [n*CNT_W +: CNT_W].
- o_pulse_len, output, NUM_CH*CNT_W: last measured shorter-phase length, same packing.

Behaviour:
- Reset: i_rst sampled on the i_clk edge only. Every register, including all outputs, clears to 0. Reset mid-operation discards votes, lock, armed state and measurements.
- Per channel, three-stage input shift: s0 <= i_syn, s1 <= s0, s2 <= s1. Rising edge pos = s1 & ~s2.
- Counters:
  - On a pos cycle, hcnt and lcnt both clear to 0.
  - Otherwise, hcnt increments when s1 = 1 and lcnt increments when s1 = 0.
  - Both saturate at all-ones and never wrap.
- Phase lengths at pos (CNT_W+1 bits): H = hcnt+1 and L = lcnt. The pos cycle itself belongs to the high phase.
- Armed flag:
  - The first pos after reset or after loss only sets armed.
  - That pos produces no measurement and no vote.
- On each pos with armed = 1:
  - o_period <= H+L, saturated to CNT_W bits.
  - o_pulse_len <= min(H,L), saturated to CNT_W bits.
  - Voting:
    - H>L: lo_v <= 0. If hi_v == VOTE_N-1, then o_pol <= 1, o_locked <= 1, hi_v <= 0; else hi_v++.
    - L>H: mirror case with lo_v and o_pol <= 0.
    - H==L: hi_v and lo_v both <= 0; o_pol and o_locked unchanged.
  - Votes must be consecutive; any disagreeing or equal period restarts the count.
- Commit timing: o_pol and o_locked update on the cycle after the pos cycle, i.e. the same register update as the vote.
- Loss:
  - Trigger: hcnt or lcnt reaches all-ones (no edge for about 2^CNT_W cycles).
  - Effect: o_locked <= 0, armed <= 0, hi_v = lo_v <= 0.
  - o_pol, o_period and o_pulse_len hold their last values.
- Output path: o_syn <= (o_pol & i_inv_en) ? ~s0 : s0. Latency is 2 cycles from i_syn.
  - i_inv_en takes effect on the next cycle and is not gated by o_locked.
- Channels are fully independent; no shared state.
- A pulse shorter than 1 cycle may be missed; this is accepted.

Test Plan:
- ch0 period 100 (90 high, 10 low), i_inv_en = 1 -> after armed edge plus 3 edges: o_pol[0]=1, o_locked[0]=1, o_period=100, o_pulse_len=10, o_syn[0] = inverted input delayed 2 cycles.
- ch0 period 100 (10 high, 90 low) -> o_pol=0, o_locked=1 after 3 voting edges; o_syn passes through unchanged with 2-cycle latency.
- Periods alternating high-longer, low-longer, equal (50/50) -> o_locked stays 0; votes never reach 3.
- CNT_W=8, lock achieved, then input held low -> o_locked falls exactly when lcnt hits 255; o_pol holds; the next resumed edge only re-arms.
- i_rst asserted for 1 cycle mid-lock -> next cycle all outputs 0; relock needs 1+VOTE_N edges.
- ch0 active-low vsync and ch1 active-high hsync (period 20, high 4) simultaneously -> o_pol = 2'b01; each o_period independent (ch1 = 20).

Source files
------------

// File: rtl/video_syn_polarity_norm.sv
// Multi-channel sync polarity detector and normaliser: measures high/low phases,
// commits polarity after consecutive agreeing periods, reports period, pulse width and lock.
module video_syn_polarity_norm #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 24,
    parameter int VOTE_N = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH-1:0]       i_syn,
    input  logic [NUM_CH-1:0]       i_inv_en,
    output logic [NUM_CH-1:0]       o_syn,
    output logic [NUM_CH-1:0]       o_pol,
    output logic [NUM_CH-1:0]       o_locked,
    output logic [NUM_CH*CNT_W-1:0] o_period,
    output logic [NUM_CH*CNT_W-1:0] o_pulse_len
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [3:0]       VOTE_LAST = 4'(VOTE_N - 1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             s0, s1, s2;
        logic             pos;
        logic [CNT_W-1:0] hcnt, lcnt;
        logic [CNT_W-1:0] hcnt_d, lcnt_d;
        logic             armed;
        logic [3:0]       hi_v, lo_v;
        logic [CNT_W:0]   ph_h, ph_l, shorter;
        logic [CNT_W+1:0] sum;
        logic [CNT_W-1:0] period_sat, pulse_sat;
        logic             loss;
        logic             pol, locked, syn_out;
        logic [CNT_W-1:0] period, pulse_len;

        assign pos = s1 & ~s2;

        always_comb begin
            hcnt_d = hcnt;
            lcnt_d = lcnt;
            if (pos) begin
                hcnt_d = '0;
                lcnt_d = '0;
            end else if (s1) begin
                if (hcnt != CNT_MAX) hcnt_d = hcnt + CNT_W'(1);
            end else begin
                if (lcnt != CNT_MAX) lcnt_d = lcnt + CNT_W'(1);
            end
        end

        // Loss fires on the same edge a counter reaches all-ones; a pos clears both, so never overlaps.
        assign loss = (hcnt_d == CNT_MAX) || (lcnt_d == CNT_MAX);

        // The pos cycle itself is the first cycle of the high phase, hence the +1.
        assign ph_h       = {1'b0, hcnt} + (CNT_W+1)'(1);
        assign ph_l       = {1'b0, lcnt};
        assign sum        = {1'b0, ph_h} + {1'b0, ph_l};
        assign shorter    = (ph_h < ph_l) ? ph_h : ph_l;
        assign period_sat = (sum > {2'b00, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
        assign pulse_sat  = shorter[CNT_W] ? CNT_MAX : shorter[CNT_W-1:0];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                s0        <= 1'b0;
                s1        <= 1'b0;
                s2        <= 1'b0;
                hcnt      <= '0;
                lcnt      <= '0;
                armed     <= 1'b0;
                hi_v      <= '0;
                lo_v      <= '0;
                pol       <= 1'b0;
                locked    <= 1'b0;
                period    <= '0;
                pulse_len <= '0;
                syn_out   <= 1'b0;
            end else begin
                s0      <= i_syn[g];
                s1      <= s0;
                s2      <= s1;
                hcnt    <= hcnt_d;
                lcnt    <= lcnt_d;
                syn_out <= (pol & i_inv_en[g]) ? ~s0 : s0;
                if (loss) begin
                    locked <= 1'b0;
                    armed  <= 1'b0;
                    hi_v   <= '0;
                    lo_v   <= '0;
                end else if (pos) begin
                    if (!armed) begin
                        armed <= 1'b1;
                    end else begin
                        period    <= period_sat;
                        pulse_len <= pulse_sat;
                        if (ph_h > ph_l) begin
                            lo_v <= '0;
                            if (hi_v == VOTE_LAST) begin
                                pol    <= 1'b1;
                                locked <= 1'b1;
                                hi_v   <= '0;
                            end else begin
                                hi_v <= hi_v + 4'd1;
                            end
                        end else if (ph_l > ph_h) begin
                            hi_v <= '0;
                            if (lo_v == VOTE_LAST) begin
                                pol    <= 1'b0;
                                locked <= 1'b1;
                                lo_v   <= '0;
                            end else begin
                                lo_v <= lo_v + 4'd1;
                            end
                        end else begin
                            hi_v <= '0;
                            lo_v <= '0;
                        end
                    end
                end
            end
        end

        assign o_syn[g]                      = syn_out;
        assign o_pol[g]                      = pol;
        assign o_locked[g]                   = locked;
        assign o_period[g*CNT_W +: CNT_W]    = period;
        assign o_pulse_len[g*CNT_W +: CNT_W] = pulse_len;
    end

endmodule

// File: tb/tb_video_syn_polarity_norm.sv
// Bench for video_syn_polarity_norm: random phase-based sync stimulus, a period-level
// polarity model, and per-channel expected queues drained by a negedge monitor.
module tb_video_syn_polarity_norm;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int VN  = 3;
    localparam int SAT = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    syn = '0;
    logic [NCH-1:0]    inv = '0;
    logic [NCH-1:0]    syn_w, pol_w, locked_w;
    logic [NCH*CW-1:0] period_w, pulse_w;

    video_syn_polarity_norm #(.NUM_CH(NCH), .CNT_W(CW), .VOTE_N(VN)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_syn       (syn),
        .i_inv_en    (inv),
        .o_syn       (syn_w),
        .o_pol       (pol_w),
        .o_locked    (locked_w),
        .o_period    (period_w),
        .o_pulse_len (pulse_w)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    typedef struct {
        int   due;
        logic pol;
        logic locked;
        int   period;
        int   pulse;
    } meas_t;

    typedef struct {
        int   due;
        logic v;
    } syn_t;

    meas_t meas_q[NCH][$];
    syn_t  syn_q[NCH][$];
    logic  done = 1'b0;

    // Driver and reference model state
    int   val[NCH], rem[NCH], cur_h[NCH], cur_l[NCH];
    int   mode[NCH], fix_h[NCH], fix_l[NCH], alt_idx[NCH];
    int   m_armed[NCH], m_run[NCH], m_sign[NCH], m_period[NCH], m_pulse[NCH];
    logic [NCH-1:0] m_pol, m_locked;

    task automatic push_meas(input int ch, input int due);
        meas_t r;
        r.due    = due;
        r.pol    = m_pol[ch];
        r.locked = m_locked[ch];
        r.period = m_period[ch];
        r.pulse  = m_pulse[ch];
        meas_q[ch].push_back(r);
    endtask

    task automatic model_clear();
        for (int ch = 0; ch < NCH; ch++) begin
            m_armed[ch] = 0; m_run[ch] = 0; m_sign[ch] = 0;
            m_period[ch] = 0; m_pulse[ch] = 0;
            val[ch] = 0; rem[ch] = $urandom_range(2, 6);
            cur_h[ch] = 1; cur_l[ch] = 1;
        end
        m_pol = '0;
        m_locked = '0;
    endtask

    // A full period (high then low) just ended at this rising edge.
    task automatic model_rise(input int ch, input int n);
        int hv, lv, sgn;
        if (m_armed[ch] == 0) begin
            m_armed[ch] = 1;
        end else begin
            hv = cur_h[ch];
            lv = cur_l[ch];
            m_period[ch] = (hv + lv > SAT) ? SAT : hv + lv;
            m_pulse[ch]  = (hv < lv) ? hv : lv;
            sgn = (hv > lv) ? 1 : ((hv < lv) ? -1 : 0);
            if (sgn == 0) m_run[ch] = 0;
            else if (sgn == m_sign[ch]) m_run[ch]++;
            else m_run[ch] = 1;
            m_sign[ch] = sgn;
            if (m_run[ch] >= VN) begin
                m_pol[ch]    = (sgn > 0);
                m_locked[ch] = 1'b1;
            end
        end
        push_meas(ch, n + 3);
    endtask

    // A low phase of 255 or more cycles saturates the low counter: lock and arming are lost.
    task automatic model_low(input int ch, input int n);
        if (cur_l[ch] >= SAT) begin
            push_meas(ch, n + 256);
            m_locked[ch] = 1'b0;
            m_armed[ch]  = 0;
            m_run[ch]    = 0;
            m_sign[ch]   = 0;
            push_meas(ch, n + 257);
        end
    endtask

    task automatic next_phase(input int ch);
        case (mode[ch])
            1: begin cur_h[ch] = fix_h[ch]; cur_l[ch] = fix_l[ch]; end
            2: begin
                case (alt_idx[ch] % 3)
                    0:       begin cur_h[ch] = 60; cur_l[ch] = 40; end
                    1:       begin cur_h[ch] = 30; cur_l[ch] = 70; end
                    default: begin cur_h[ch] = 50; cur_l[ch] = 50; end
                endcase
                alt_idx[ch]++;
            end
            3: begin cur_h[ch] = fix_h[ch]; cur_l[ch] = 300; mode[ch] = 1; end
            4: begin cur_h[ch] = 200; cur_l[ch] = 100; end
            default: begin
                cur_h[ch] = $urandom_range(1, 60);
                cur_l[ch] = $urandom_range(1, 60);
            end
        endcase
    endtask

    task automatic step();
        syn_t s;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (rem[ch] == 0) begin
                if (val[ch] != 0) begin
                    val[ch] = 0;
                    rem[ch] = cur_l[ch];
                    model_low(ch, cyc);
                end else begin
                    model_rise(ch, cyc);
                    next_phase(ch);
                    val[ch] = 1;
                    rem[ch] = cur_h[ch];
                end
            end
            rem[ch]--;
            syn[ch] = (val[ch] != 0);
            s.due = cyc + 2;
            s.v   = syn[ch];
            syn_q[ch].push_back(s);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        syn = '0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        model_clear();
    endtask

    task automatic set_fixed(input int ch, input int h, input int l);
        mode[ch] = 1; fix_h[ch] = h; fix_l[ch] = l;
    endtask

    initial begin
        for (int ch = 0; ch < NCH; ch++) begin
            mode[ch] = 0; fix_h[ch] = 1; fix_l[ch] = 1; alt_idx[ch] = 0;
        end
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        run(300);
        // Active-low vsync on ch0 with normalisation enabled
        set_fixed(0, 90, 10); mode[1] = 0; inv = 2'b01;
        run(700);
        // Active-high vsync: no inversion even with enable set
        do_reset();
        set_fixed(0, 10, 90); inv = 2'b11;
        run(600);
        // Alternating high-longer / low-longer / equal never commits
        do_reset();
        mode[0] = 2; mode[1] = 2; alt_idx[0] = 0; alt_idx[1] = 1; inv = 2'b00;
        run(1200);
        // Lock, then one 300-cycle low phase forces loss and re-arm
        set_fixed(0, 90, 10); mode[1] = 0; inv = 2'b01;
        run(500);
        mode[0] = 3;
        run(1000);
        // Reset in the middle of lock, then relock
        do_reset();
        set_fixed(0, 90, 10);
        run(600);
        // Both channels simultaneously: active-low vsync, active-high hsync
        set_fixed(0, 80, 20); set_fixed(1, 4, 16); inv = 2'b11;
        run(600);
        // Period sum beyond the counter range saturates
        mode[0] = 4; mode[1] = 0;
        run(1200);
        // Fully random phases and enable changes
        mode[0] = 0; mode[1] = 0;
        for (int k = 0; k < 10; k++) begin
            inv = 2'($urandom_range(0, 3));
            run(150);
        end
        @(posedge clk);
        #1;
        syn = '0;
        repeat (10) @(posedge clk);
        done = 1'b1;
    end

    // Monitor and scoreboard
    int             tests = 0;
    int             fails = 0;
    logic [NCH-1:0] exp_pol = '0;
    logic [NCH-1:0] inv_last = '0;

    task automatic chk(input string name, input int ch, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s ch%0d cycle %0d: got %0d, expected %0d", name, ch, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        syn_t  sr;
        meas_t mr;
        if (rst_q) begin
            for (int ch = 0; ch < NCH; ch++) begin
                chk("rst_syn", ch, int'(syn_w[ch]), 0);
                chk("rst_pol", ch, int'(pol_w[ch]), 0);
                chk("rst_locked", ch, int'(locked_w[ch]), 0);
                chk("rst_period", ch, int'(period_w[ch*CW +: CW]), 0);
                chk("rst_pulse", ch, int'(pulse_w[ch*CW +: CW]), 0);
                meas_q[ch].delete();
                syn_q[ch].delete();
            end
            exp_pol = '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (syn_q[ch].size() > 0 && syn_q[ch][0].due <= cyc) begin
                    sr = syn_q[ch].pop_front();
                    chk("o_syn", ch, int'(syn_w[ch]), int'(sr.v ^ (exp_pol[ch] & inv_last[ch])));
                end
                while (meas_q[ch].size() > 0 && meas_q[ch][0].due <= cyc) begin
                    mr = meas_q[ch].pop_front();
                    chk("o_pol", ch, int'(pol_w[ch]), int'(mr.pol));
                    chk("o_locked", ch, int'(locked_w[ch]), int'(mr.locked));
                    chk("o_period", ch, int'(period_w[ch*CW +: CW]), mr.period);
                    chk("o_pulse_len", ch, int'(pulse_w[ch*CW +: CW]), mr.pulse);
                    exp_pol[ch] = mr.pol;
                end
            end
        end
        inv_last = inv;
        if (done) begin
            for (int ch = 0; ch < NCH; ch++) begin
                chk("leftover_meas", ch, meas_q[ch].size(), 0);
                chk("leftover_syn", ch, syn_q[ch].size(), 0);
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
